ordered_set_assembler: RTL and testbench
========================================

Name: ordered_set_assembler

Overview:
- Upstream feeder of the RX LTSSM.
- Collects per-lane descrambled/decoded symbol streams (16 lanes, one 8-bit symbol per lane per clock) into 16-symbol (128-bit) ordered sets.
- Aligns completion across the active lanes and presents one 2048-bit bundle with a single-cycle valid strobe.
- Lanes outside the active range are driven to zero.

Parameters:
- LANES, 16, number of physical lanes (bundle width = LANES*128).
- MAX_SKEW, 8, cycles a partially complete bundle may wait for the remaining active lanes before being discarded.
- COM_SYMBOL, 8'hBC, K-symbol value that starts an ordered set.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- symbols  input  LANES*8  lane i symbol at [i*8+7:i*8]
- kFlags  input  LANES  lane i symbol is a K character
- symbolsValid  input  1  symbols/kFlags qualified this cycle
- numberOfDetectedLanes  input  5  active lanes 0..N-1
- rxElectricalIdle  input  1  flush request
- orderedSets  output  LANES*128  lane i set at [i*128+127:i*128]; symbol k at bits [k*8+7:k*8] of the slice
- validOrderedSets  output  1  one-cycle strobe, bundle valid
- skewError  output  1  one-cycle pulse, bundle discarded on skew timeout

Behaviour:
- Reset (reset=0, async): all lane counters 0, ready flags 0, hold buffers 0, orderedSets=0, validOrderedSets=0, skewError=0, skew timer 0.
- Active lane count A = min(numberOfDetectedLanes,16). If A=0, no strobe is ever produced and all lane state is held cleared.
- Per-lane FSM, states IDLE / COLLECT / READY:
  - IDLE: on symbolsValid && kFlags[i] && symbol==COM_SYMBOL, store COM as symbol 0, count=1, go to COLLECT. Other symbols are ignored.
  - COLLECT: on each symbolsValid, store symbol at index count and increment count.
    - If the stored symbol is a COM, abort: restart with this COM as symbol 0, count=1.
    - When symbol 15 is stored: go to READY; hold buffer = the 16 symbols.
  - READY: symbols are ignored until emission or discard, after which the lane goes to IDLE.
  - Cycles without symbolsValid never advance any counter.
- Emission:
  - In the cycle in which every lane 0..A-1 is READY (counting lanes reaching READY that cycle), on the next clock:
    - orderedSets <= hold buffers for lanes < A, zero for lanes >= A.
    - validOrderedSets <= 1 for exactly one cycle.
    - All lanes return to IDLE.
  - Latency: last symbol accepted at edge t, strobe high during cycle t+1.
  - orderedSets holds its value until the next emission.
- Skew timer:
  - Runs while at least one active lane is READY but not all are.
  - When it reaches MAX_SKEW without emission: all lanes are cleared to IDLE, skewError pulses for 1 cycle, and the timer is cleared.
  - Emission in the same cycle as the timeout wins: no skewError.
- Lanes >= A are not considered for emission.
- A change of numberOfDetectedLanes is used from the next cycle.
- rxElectricalIdle=1: all lanes are forced to IDLE and the timer is cleared; orderedSets retains its last value; no strobe that cycle. This has priority over emission.
- Back-to-back sets: a COM arriving in the cycle after emission starts a new set normally.

Optional Feature:
- Macro ORDERED_SET_TS_CHECK_EN.
- Defined: on completion, a lane checks symbols 6..15. All must equal 8'h4A (TS1) or all must equal 8'h45 (TS2); otherwise the set is dropped and the lane returns to IDLE instead of entering READY.
- Undefined: no content check; any 16-symbol set starting with COM becomes READY.

Test Plan:
- A=4; lanes 0-3 fed COM then 15 symbols 8'h01..8'h0F in lockstep -> validOrderedSets high exactly one cycle after the 16th symbol; lane slices [127:0]..[511:384] = {0F..01,BC}; bits [2047:512]=0.
- A=2; lane 1 is 3 cycles behind lane 0 (MAX_SKEW=8) -> a single strobe when lane 1 completes, containing both sets.
- A=2; lane 1 never sends COM -> skewError pulses 8 cycles after lane 0 reaches READY; no strobe; lane 0 then accepts a new set.
- COM appears at symbol index 9 of a lane -> set restarts there; strobe only after 15 further symbols.
- rxElectricalIdle pulsed mid-collection, then symbolsValid gaps -> no strobe; orderedSets unchanged; a fresh set completes normally.
- reset asserted mid-collection -> all outputs 0 immediately (asynchronous).
- With ORDERED_SET_TS_CHECK_EN: a set with symbol 10 = 8'h00 is dropped, no strobe; an all-4A set is emitted.

Source files
------------

// File: rtl/ordered_set_assembler.sv
// Per-lane ordered-set collection with cross-lane alignment, skew timeout and flush.
// Optional ORDERED_SET_TS_CHECK_EN: drop completed sets whose symbols 6..15 are not all TS1 or all TS2.
//
// Lane FSM states:
//   state     | meaning
//   S_IDLE    | waiting for a COM K-symbol
//   S_COLLECT | storing symbols 1..15 into the lane hold buffer
//   S_READY   | 16-symbol set held, waiting for the other active lanes
module ordered_set_assembler #(
  parameter int          LANES      = 16,
  parameter int          MAX_SKEW   = 8,
  parameter logic [7:0]  COM_SYMBOL = 8'hBC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LANES*8-1:0]   symbols,
  input  logic [LANES-1:0]     kFlags,
  input  logic                 symbolsValid,
  input  logic [4:0]           numberOfDetectedLanes,
  input  logic                 rxElectricalIdle,
  output logic [LANES*128-1:0] orderedSets,
  output logic                 validOrderedSets,
  output logic                 skewError
);

  localparam int AW = $clog2(LANES + 1);
  localparam int TW = $clog2(MAX_SKEW + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_READY} lane_state_t;

  lane_state_t    state_q [LANES];
  lane_state_t    state_d [LANES];
  logic [3:0]     count_q [LANES];
  logic [3:0]     count_d [LANES];
  logic [127:0]   hold_q  [LANES];
  logic [127:0]   hold_d  [LANES];

  logic [AW-1:0]    active_q;
  logic [AW-1:0]    active_d;
  logic [TW-1:0]    timer_q;
  logic [TW-1:0]    timer_d;
  logic [LANES-1:0] active;
  logic [LANES-1:0] is_com;
  logic [LANES-1:0] done;
  logic [LANES-1:0] ready_now;
  logic             all_done;
  logic             running;
  logic             emit;
  logic             timeout;

`ifdef ORDERED_SET_TS_CHECK_EN
  function automatic logic ts_ok(input logic [127:0] s);
    logic all_ts1;
    logic all_ts2;
    all_ts1 = 1'b1;
    all_ts2 = 1'b1;
    for (int k = 6; k < 16; k++) begin
      if (s[k*8 +: 8] != 8'h4A) all_ts1 = 1'b0;
      if (s[k*8 +: 8] != 8'h45) all_ts2 = 1'b0;
    end
    return all_ts1 || all_ts2;
  endfunction
`endif

  // Lane count is registered so a change takes effect on the following cycle.
  always_comb begin
    if (int'(numberOfDetectedLanes) > LANES) active_d = AW'(LANES);
    else                                     active_d = AW'(numberOfDetectedLanes);
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      active[i]    = (i < int'(active_q));
      is_com[i]    = kFlags[i] && (symbols[i*8 +: 8] == COM_SYMBOL);
      ready_now[i] = (state_q[i] == S_READY);
      state_d[i]   = state_q[i];
      count_d[i]   = count_q[i];
      hold_d[i]    = hold_q[i];
      done[i]      = 1'b0;

      case (state_q[i])
        S_IDLE: begin
          if (symbolsValid && is_com[i]) begin
            hold_d[i][7:0] = symbols[i*8 +: 8];
            count_d[i]     = 4'd1;
            state_d[i]     = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (symbolsValid) begin
            if (is_com[i]) begin
              hold_d[i][7:0] = symbols[i*8 +: 8];
              count_d[i]     = 4'd1;
            end else begin
              hold_d[i][{count_q[i], 3'b000} +: 8] = symbols[i*8 +: 8];
              count_d[i] = count_q[i] + 4'd1;
              if (count_q[i] == 4'd15) begin
`ifdef ORDERED_SET_TS_CHECK_EN
                if (ts_ok(hold_d[i])) begin
                  state_d[i] = S_READY;
                  done[i]    = 1'b1;
                end else begin
                  state_d[i] = S_IDLE;
                end
`else
                state_d[i] = S_READY;
                done[i]    = 1'b1;
`endif
              end
            end
          end
        end
        S_READY: done[i] = 1'b1;
        default: state_d[i] = S_IDLE;
      endcase
    end

    // A lane completing this cycle counts toward alignment; idle lanes outside the range never block it.
    all_done = (active_q != '0) && ((done | ~active) == '1);
    running  = ((ready_now & active) != '0) && ((ready_now | ~active) != '1);
    emit     = !rxElectricalIdle && all_done;
    timeout  = !rxElectricalIdle && !emit && running && (timer_q >= TW'(MAX_SKEW - 1));

    if (rxElectricalIdle || emit || timeout || !running) timer_d = '0;
    else                                                  timer_d = timer_q + 1'b1;

    for (int i = 0; i < LANES; i++) begin
      if (rxElectricalIdle || emit || timeout || !active[i]) begin
        state_d[i] = S_IDLE;
        count_d[i] = '0;
      end
      if (!active[i]) hold_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= S_IDLE;
        count_q[i] <= '0;
        hold_q[i]  <= '0;
      end
      active_q         <= '0;
      timer_q          <= '0;
      orderedSets      <= '0;
      validOrderedSets <= 1'b0;
      skewError        <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
        hold_q[i]  <= hold_d[i];
      end
      active_q         <= active_d;
      timer_q          <= timer_d;
      validOrderedSets <= emit;
      skewError        <= timeout;
      if (emit) begin
        for (int i = 0; i < LANES; i++)
          orderedSets[i*128 +: 128] <= active[i] ? hold_d[i] : 128'd0;
      end
    end
  end

endmodule

// File: tb/tb_ordered_set_assembler.sv
// Scoreboard bench for ordered_set_assembler: stimulus pushes expected bundles/skew pulses, a monitor pops and compares.
module tb_ordered_set_assembler;

  localparam int LANES = 16;

`ifdef ORDERED_SET_TS_CHECK_EN
  localparam logic [127:0] L1 = 128'h4A4A4A4A4A4A4A4A4A4A0504030201BC;
  localparam logic [127:0] L2 = 128'h4A4A4A4A4A4A4A4A4A4A1514131211BC;
`else
  localparam logic [127:0] L1 = 128'h0F0E0D0C0B0A090807060504030201BC;
  localparam logic [127:0] L2 = 128'h1F1E1D1C1B1A191817161514131211BC;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [LANES*8-1:0]   symbols = '0;
  logic [LANES-1:0]     kFlags = '0;
  logic                 symbolsValid = 1'b0;
  logic [4:0]           numberOfDetectedLanes = '0;
  logic                 rxElectricalIdle = 1'b0;
  logic [LANES*128-1:0] orderedSets;
  logic                 validOrderedSets;
  logic                 skewError;

  ordered_set_assembler dut (
    .clk                   (clk),
    .reset                 (reset),
    .symbols               (symbols),
    .kFlags                (kFlags),
    .symbolsValid          (symbolsValid),
    .numberOfDetectedLanes (numberOfDetectedLanes),
    .rxElectricalIdle      (rxElectricalIdle),
    .orderedSets           (orderedSets),
    .validOrderedSets      (validOrderedSets),
    .skewError             (skewError)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   cyc;
    logic [LANES*128-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   skew_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t e_mon;
  int   s_mon;
  logic [LANES*128-1:0] snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bundle(input string name, input logic [LANES*128-1:0] act,
                              input logic [LANES*128-1:0] exp);
    int bad;
    checks++;
    bad = -1;
    for (int i = LANES - 1; i >= 0; i--)
      if (act[i*128 +: 128] !== exp[i*128 +: 128]) bad = i;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s lane %0d: got %h expected %h", name, bad,
               act[bad*128 +: 128], exp[bad*128 +: 128]);
    end
  endtask

  function automatic logic [7:0] sym_of(input logic [7:0] base, input int k);
    if (k == 0) return 8'hBC;
`ifdef ORDERED_SET_TS_CHECK_EN
    if (k >= 6) return 8'h4A;
`endif
    return base + 8'(k);
  endfunction

  function automatic logic [LANES*128-1:0] bundle_rep(input logic [127:0] v, input int n);
    logic [LANES*128-1:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[i*128 +: 128] = v;
    return b;
  endfunction

  task automatic step(input logic [LANES*8-1:0] s, input logic [LANES-1:0] k, input logic v);
    symbols      = s;
    kFlags       = k;
    symbolsValid = v;
    @(posedge clk);
    #1;
    symbolsValid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  task automatic send_sym(input logic [LANES-1:0] mask, input logic [7:0] s, input logic kf);
    logic [LANES*8-1:0] sv;
    sv = '0;
    for (int i = 0; i < LANES; i++) if (mask[i]) sv[i*8 +: 8] = s;
    step(sv, kf ? mask : '0, 1'b1);
  endtask

  task automatic send_set(input logic [LANES-1:0] mask, input logic [7:0] base);
    for (int k = 0; k < 16; k++) send_sym(mask, sym_of(base, k), k == 0);
  endtask

  task automatic push_exp(input logic [LANES*128-1:0] d);
    exp_t e;
    e.cyc  = cyc;
    e.data = d;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (validOrderedSets) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
        end else begin
          e_mon = exp_q.pop_front();
          check("strobe_cycle", 128'(cyc), 128'(e_mon.cyc));
          check_bundle("strobe_data", orderedSets, e_mon.data);
        end
      end
      if (skewError) begin
        if (skew_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_skew: got skewError at cycle %0d expected none", cyc);
        end else begin
          s_mon = skew_q.pop_front();
          check("skew_cycle", 128'(cyc), 128'(s_mon));
        end
      end
    end
  end

  initial begin
    logic [LANES*8-1:0] sv;
    logic [LANES-1:0]   kv;
    logic [LANES*128-1:0] b;

    #3;
    check("reset_valid", 128'(validOrderedSets), 128'd0);
    check("reset_skew", 128'(skewError), 128'd0);
    check_bundle("reset_sets", orderedSets, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Four lanes in lockstep
    numberOfDetectedLanes = 5'd4;
    idle(1);
    send_set(16'h000F, 8'h00);
    push_exp(bundle_rep(L1, 4));
    idle(2);

    // Lane 1 three cycles behind lane 0
    numberOfDetectedLanes = 5'd2;
    idle(1);
    for (int k = 0; k < 19; k++) begin
      sv = '0;
      kv = '0;
      if (k < 16) begin
        sv[7:0] = sym_of(8'h00, k);
        kv[0]   = (k == 0);
      end
      if (k >= 3) begin
        sv[15:8] = sym_of(8'h10, k - 3);
        kv[1]    = (k == 3);
      end
      step(sv, kv, 1'b1);
    end
    b = '0;
    b[127:0]   = L1;
    b[255:128] = L2;
    push_exp(b);
    idle(2);

    // Lane 1 silent: skew timeout, then recovery
    send_set(16'h0001, 8'h00);
    skew_q.push_back(cyc + 8);
    idle(12);
    send_set(16'h0003, 8'h10);
    push_exp(bundle_rep(L2, 2));
    idle(2);

    // COM at symbol index 9 restarts the set
    for (int k = 0; k < 9; k++) send_sym(16'h0003, sym_of(8'h00, k), k == 0);
    send_sym(16'h0003, 8'hBC, 1'b1);
    for (int k = 1; k < 16; k++) send_sym(16'h0003, sym_of(8'h00, k), 1'b0);
    push_exp(bundle_rep(L1, 2));
    idle(2);

    // Electrical idle mid-collection, then gaps
    snap = orderedSets;
    for (int k = 0; k < 5; k++) send_sym(16'h0003, sym_of(8'h00, k), k == 0);
    rxElectricalIdle = 1'b1;
    send_sym(16'h0003, sym_of(8'h00, 5), 1'b0);
    rxElectricalIdle = 1'b0;
    check("flush_no_strobe", 128'(validOrderedSets), 128'd0);
    idle(3);
    for (int k = 6; k < 16; k++) begin
      send_sym(16'h0003, sym_of(8'h00, k), 1'b0);
      idle(1);
    end
    check_bundle("flush_sets_held", orderedSets, bundle_rep(L1, 2));
    for (int k = 0; k < 16; k++) begin
      if (k > 0) idle(1);
      send_sym(16'h0003, sym_of(8'h10, k), k == 0);
    end
    push_exp(bundle_rep(L2, 2));
    idle(2);

    // Asynchronous reset mid-collection
    for (int k = 0; k < 4; k++) send_sym(16'h0003, sym_of(8'h00, k), k == 0);
    #2;
    reset = 1'b0;
    #1;
    check_bundle("async_reset_sets", orderedSets, '0);
    check("async_reset_valid", 128'(validOrderedSets), 128'd0);
    check("async_reset_skew", 128'(skewError), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // No active lanes: nothing is ever emitted
    numberOfDetectedLanes = 5'd0;
    idle(1);
    send_set(16'hFFFF, 8'h00);
    idle(3);
    check_bundle("zero_lanes_sets", orderedSets, '0);

    // Lane count above 16 clamps to all lanes
    numberOfDetectedLanes = 5'd20;
    idle(1);
    send_set(16'hFFFF, 8'h00);
    push_exp(bundle_rep(L1, 16));
    idle(2);

`ifdef ORDERED_SET_TS_CHECK_EN
    numberOfDetectedLanes = 5'd2;
    idle(1);
    for (int k = 0; k < 16; k++)
      send_sym(16'h0003, (k == 10) ? 8'h00 : sym_of(8'h00, k), k == 0);
    idle(3);
    send_set(16'h0003, 8'h00);
    push_exp(bundle_rep(L1, 2));
    idle(2);
`endif

    idle(12);
    check("strobes_outstanding", 128'(exp_q.size()), 128'd0);
    check("skews_outstanding", 128'(skew_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
